ex_wb_arbiter: RTL and testbench
================================

// Module: ex_wb_arbiter
// PURPOSE
//  Parametrised writeback collector for the execute stage. Accepts results from
//  NR_FU functional units (ALU, branch, CSR, mult, load, store, ...), buffers each
//  in a per-unit queue, and drives up to NR_WB_PORTS scoreboard writeback ports per
//  cycle with round-robin fairness. Supersedes the fixed FLU/load/store result muxing.
// PARAMETERS
//  NR_FU        default 4   number of producing functional units (>=1)
//  NR_WB_PORTS  default 2   writeback ports into scoreboard (1..NR_FU)
//  DEPTH        default 2   per-unit queue entries; power of two, >=2
// PORTS
//  clk_i           in   1                        clock
//  rst_i           in   1                        reset; asynchronous, active-high
//  flush_i         in   1                        pipeline flush, synchronous discard
//  fu_valid_i      in   NR_FU                    unit result valid
//  fu_ready_o      out  NR_FU                    unit queue can accept
//  fu_result_i     in   NR_FU x riscv::XLEN      result data
//  fu_trans_id_i   in   NR_FU x TRANS_ID_BITS    scoreboard transaction id
//  fu_exception_i  in   NR_FU x exception_t      exception (valid bit inside)
//  wb_valid_o      out  NR_WB_PORTS              writeback valid
//  wb_ready_i      in   NR_WB_PORTS              scoreboard accepts on port
//  wb_result_o     out  NR_WB_PORTS x XLEN       writeback data
//  wb_trans_id_o   out  NR_WB_PORTS x TRANS_ID_BITS
//  wb_exception_o  out  NR_WB_PORTS x exception_t
//  conflict_o      out  1                        more non-empty queues than ports
// BEHAVIOUR
//  - Reset: all queues empty, rr pointer = 0, wb_valid_o = 0, fu_ready_o = all 1,
//    conflict_o = 0; wb data outputs = '0.
//  - Push: fu_valid_i[i] & fu_ready_o[i] stores {result,trans_id,exception} at tail.
//    fu_ready_o[i] = !full[i] (registered count; no same-cycle pop credit).
//  - Latency: entry pushed in cycle n is eligible for writeback in n+1 at the earliest.
//  - Per-unit order strictly FIFO; no ordering across units.
//  - Grant (combinational from queue heads): scan units in order rr_q, rr_q+1, ...
//    mod NR_FU; k-th non-empty unit found maps to port k, k < NR_WB_PORTS.
//    wb_valid_o[k] = 1 iff a unit mapped; unused ports valid 0, data '0.
//  - Pop: unit mapped to port k pops iff wb_ready_i[k]. wb_valid_o must not depend
//    on wb_ready_i; held data stays stable until accepted.
//  - rr update: if >=1 pop, rr_q <= (index of last popped unit + 1) mod NR_FU;
//    else unchanged.
//  - Simultaneous push+pop on a unit: count unchanged, both take effect; on a full
//    queue push is blocked by fu_ready_o=0 regardless of pop.
//  - Pointers wrap mod DEPTH; count width $clog2(DEPTH)+1 distinguishes full/empty.
//  - flush_i: all queues emptied next edge, push in same cycle discarded, wb_valid_o
//    forced 0 during flush cycle, rr_q retained. Flush overrides push and pop.
//  - conflict_o = registered flag: (number of non-empty queues > NR_WB_PORTS) last cycle.
//  - Reset asserted mid-operation: immediate clear of all state, outputs to reset values.
// STRUCTURE
//  - ariane_pkg: wb_entry_t {xlen_t result; logic [TRANS_ID_BITS-1:0] trans_id;
//    exception_t ex;}; reuse TRANS_ID_BITS and exception_t.
//  - Sub-module ex_wb_fifo (one per unit, generate loop): DEPTH-entry queue of
//    wb_entry_t with push/pop/flush, full/empty/head outputs.
//  - Top: rotated priority scan + port mapping, rr register, conflict register.
// TESTING
//  1 Reset: rst_i=1 mid-traffic -> wb_valid_o=0, fu_ready_o='1 within same cycle, conflict_o=0.
//  2 Single unit: FU1 pushes id=5 res=0xDEAD at cycle 3 -> wb_valid_o[0]=1, id 5, 0xDEAD at
//    cycle 4; wb_ready_i[0]=1 -> queue empty cycle 5.
//  3 Fairness NR_FU=4, NR_WB_PORTS=2, all units hold 2 entries, ready=1: grants {0,1},{2,3},
//    {0,1},{2,3}; conflict_o=1 from cycle after first overfill until <=2 queues non-empty.
//  4 Backpressure: wb_ready_i=0 for 3 cycles with FU0 pushing each cycle, DEPTH=2 ->
//    fu_ready_o[0]=0 after 2 pushes; head data stable; release -> order id 1,2,3 kept.
//  5 Flush: queues with 3 entries total plus push in flush cycle -> wb_valid_o=0 that cycle,
//    all empty next cycle, pushed entry never appears.
//  6 Exception pass-through: FU2 pushes ex.valid=1 cause=0x5 -> wb_exception_o on mapped port
//    carries valid=1 cause 0x5 with matching trans_id.

Source files
------------

// File: rtl/ex_wb_arbiter_pkg.sv
// ex_wb_arbiter_pkg: shared types and helpers for the execute-stage writeback collector
package ex_wb_arbiter_pkg;
  localparam int XLEN = 32;
  localparam int TRANS_ID_BITS = 3;
  typedef logic [XLEN-1:0] xlen_t;
  typedef struct packed {
    xlen_t cause;
    xlen_t tval;
    logic  valid;
  } exception_t;
  typedef struct packed {
    xlen_t                    result;
    logic [TRANS_ID_BITS-1:0] trans_id;
    exception_t               ex;
  } wb_entry_t;
  function automatic int wrap(input int a, input int n);
    return a >= n ? a - n : a;
  endfunction
endpackage

// File: rtl/ex_wb_fifo.sv
// ex_wb_fifo: per-unit result queue; push is ignored when full, pop when empty
module ex_wb_fifo
  import ex_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      flush_i,
  input  logic      push_i,
  input  logic      pop_i,
  input  wb_entry_t data_i,
  output wb_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] cnt_q;
  wb_entry_t mem_q [DEPTH];
  logic do_push, do_pop;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i & ~full_o;
  assign do_pop = pop_i & ~empty_o;
  assign head_o = mem_q[rd_q];
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/ex_wb_arbiter.sv
// ex_wb_arbiter: collects FU results into per-unit queues and maps heads to writeback ports round-robin
module ex_wb_arbiter
  import ex_wb_arbiter_pkg::*;
#(
  parameter int NR_FU = 4,
  parameter int NR_WB_PORTS = 2,
  parameter int DEPTH = 2
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        flush_i,
  input  logic       [NR_FU-1:0]                      fu_valid_i,
  output logic       [NR_FU-1:0]                      fu_ready_o,
  input  xlen_t      [NR_FU-1:0]                      fu_result_i,
  input  logic       [NR_FU-1:0][TRANS_ID_BITS-1:0]   fu_trans_id_i,
  input  exception_t [NR_FU-1:0]                      fu_exception_i,
  output logic       [NR_WB_PORTS-1:0]                wb_valid_o,
  input  logic       [NR_WB_PORTS-1:0]                wb_ready_i,
  output xlen_t      [NR_WB_PORTS-1:0]                wb_result_o,
  output logic       [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] wb_trans_id_o,
  output exception_t [NR_WB_PORTS-1:0]                wb_exception_o,
  output logic                                        conflict_o
);
  localparam int IW = NR_FU > 1 ? $clog2(NR_FU) : 1;
  logic [NR_FU-1:0] full, empty, pop;
  wb_entry_t head [NR_FU];
  logic [IW-1:0] rr_q, rr_d;
  int n_ne;
  for (genvar g = 0; g < NR_FU; g++) begin : g_fifo
    ex_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .flush_i(flush_i),
      .push_i (fu_valid_i[g]),
      .pop_i  (pop[g]),
      .data_i ({fu_result_i[g], fu_trans_id_i[g], fu_exception_i[g]}),
      .head_o (head[g]),
      .full_o (full[g]),
      .empty_o(empty[g])
    );
  end
  assign fu_ready_o = ~full;
  // n_ne doubles as the port cursor: the k-th non-empty unit in rotated order takes port k
  always_comb begin
    wb_valid_o = '0;
    wb_result_o = '0;
    wb_trans_id_o = '0;
    wb_exception_o = '0;
    pop = '0;
    rr_d = rr_q;
    n_ne = 0;
    for (int j = 0; j < NR_FU; j++) begin
      for (int u = 0; u < NR_FU; u++) begin
        if (u == wrap(int'(rr_q) + j, NR_FU) && !empty[u]) begin
          for (int p = 0; p < NR_WB_PORTS; p++) begin
            if (p == n_ne && !flush_i) begin
              wb_valid_o[p] = 1'b1;
              wb_result_o[p] = head[u].result;
              wb_trans_id_o[p] = head[u].trans_id;
              wb_exception_o[p] = head[u].ex;
              if (wb_ready_i[p]) begin
                pop[u] = 1'b1;
                rr_d = IW'(wrap(u + 1, NR_FU));
              end
            end
          end
          n_ne = n_ne + 1;
        end
      end
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q <= '0;
      conflict_o <= 1'b0;
    end else begin
      rr_q <= rr_d;
      conflict_o <= n_ne > NR_WB_PORTS;
    end
  end
endmodule

// File: tb/tb_ex_wb_arbiter.sv
// tb_ex_wb_arbiter: directed checks of queueing, round-robin grant, backpressure, flush and reset
module tb_ex_wb_arbiter;
  import ex_wb_arbiter_pkg::*;
  localparam int NF = 4;
  localparam int NP = 2;
  logic clk, rst, flush;
  logic [NF-1:0] fu_valid, fu_ready;
  xlen_t [NF-1:0] fu_result;
  logic [NF-1:0][TRANS_ID_BITS-1:0] fu_trans_id;
  exception_t [NF-1:0] fu_exception;
  logic [NP-1:0] wb_valid, wb_ready;
  xlen_t [NP-1:0] wb_result;
  logic [NP-1:0][TRANS_ID_BITS-1:0] wb_trans_id;
  exception_t [NP-1:0] wb_exception;
  logic conflict;
  int n_chk, n_fail;
  ex_wb_arbiter #(.NR_FU(NF), .NR_WB_PORTS(NP), .DEPTH(2)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .fu_valid_i(fu_valid), .fu_ready_o(fu_ready), .fu_result_i(fu_result),
    .fu_trans_id_i(fu_trans_id), .fu_exception_i(fu_exception),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_result_o(wb_result),
    .wb_trans_id_o(wb_trans_id), .wb_exception_o(wb_exception), .conflict_o(conflict)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    fu_valid = '0;
    wb_ready = '0;
    flush = 0;
  endtask
  task automatic push(input int u, input int id, input int res);
    fu_valid[u] = 1'b1;
    fu_trans_id[u] = TRANS_ID_BITS'(id);
    fu_result[u] = xlen_t'(res);
    fu_exception[u] = '0;
  endtask
  task automatic do_reset();
    cyc();
    rst = 1;
    #2 rst = 0;
  endtask
  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1;
    flush = 0;
    fu_valid = '0;
    wb_ready = '0;
    fu_result = '0;
    fu_trans_id = '0;
    fu_exception = '0;
    @(negedge clk);
    #1;
    check("rst_valid", 64'(wb_valid), 0);
    check("rst_ready", 64'(fu_ready), 64'hf);
    check("rst_conflict", 64'(conflict), 0);
    check("rst_result", 64'(wb_result), 0);
    rst = 0;
    // single unit latency
    cyc(); push(1, 5, 'hDEAD); #1;
    check("single_not_yet", 64'(wb_valid), 0);
    cyc(); wb_ready = 2'b01; #1;
    check("single_valid", 64'(wb_valid), 64'b01);
    check("single_id", 64'(wb_trans_id[0]), 5);
    check("single_res", 64'(wb_result[0]), 64'hDEAD);
    cyc(); #1;
    check("single_empty", 64'(wb_valid), 0);
    check("single_ready", 64'(fu_ready), 64'hf);
    // fairness across four full queues
    do_reset();
    for (int u = 0; u < NF; u++) push(u, u * 2, u);
    #1 check("fair_conf0", 64'(conflict), 0);
    cyc();
    for (int u = 0; u < NF; u++) push(u, u * 2 + 1, u);
    #1 check("fair_conf1", 64'(conflict), 0);
    begin
      int exp_ids [4][2] = '{'{0, 2}, '{4, 6}, '{1, 3}, '{5, 7}};
      for (int r = 0; r < 4; r++) begin
        cyc(); wb_ready = 2'b11; #1;
        check($sformatf("fair_valid_%0d", r), 64'(wb_valid), 64'b11);
        check($sformatf("fair_p0_%0d", r), 64'(wb_trans_id[0]), 64'(exp_ids[r][0]));
        check($sformatf("fair_p1_%0d", r), 64'(wb_trans_id[1]), 64'(exp_ids[r][1]));
        check($sformatf("fair_conf_%0d", r), 64'(conflict), 1);
      end
    end
    cyc(); #1;
    check("fair_done_valid", 64'(wb_valid), 0);
    check("fair_done_conf", 64'(conflict), 0);
    // asynchronous reset mid-traffic
    do_reset();
    for (int u = 0; u < NF; u++) push(u, u, u);
    cyc(); cyc(); #1;
    check("mid_pre_conf", 64'(conflict), 1);
    check("mid_pre_valid", 64'(wb_valid), 64'b11);
    #2 rst = 1;
    #1;
    check("mid_valid", 64'(wb_valid), 0);
    check("mid_ready", 64'(fu_ready), 64'hf);
    check("mid_conf", 64'(conflict), 0);
    check("mid_id", 64'(wb_trans_id), 0);
    rst = 0;
    // backpressure on unit 0
    do_reset();
    push(0, 1, 'h11); #1;
    check("bp_ready1", 64'(fu_ready[0]), 1);
    cyc(); push(0, 2, 'h22); #1;
    check("bp_ready2", 64'(fu_ready[0]), 1);
    check("bp_head1", 64'(wb_trans_id[0]), 1);
    cyc(); push(0, 3, 'h33); #1;
    check("bp_full", 64'(fu_ready[0]), 0);
    check("bp_stable_id", 64'(wb_trans_id[0]), 1);
    check("bp_stable_res", 64'(wb_result[0]), 64'h11);
    cyc(); push(0, 3, 'h33); wb_ready = 2'b01; #1;
    check("bp_nocredit", 64'(fu_ready[0]), 0);
    check("bp_out1", 64'(wb_trans_id[0]), 1);
    cyc(); push(0, 3, 'h33); wb_ready = 2'b01; #1;
    check("bp_ready3", 64'(fu_ready[0]), 1);
    check("bp_out2", 64'(wb_trans_id[0]), 2);
    cyc(); wb_ready = 2'b01; #1;
    check("bp_out3", 64'(wb_trans_id[0]), 3);
    check("bp_out3_res", 64'(wb_result[0]), 64'h33);
    cyc(); #1;
    check("bp_empty", 64'(wb_valid), 0);
    // flush discards queued and same-cycle pushes
    do_reset();
    push(0, 1, 1); push(1, 2, 2);
    cyc(); push(0, 3, 3); #1;
    check("fl_pre_valid", 64'(wb_valid), 64'b11);
    cyc(); flush = 1; push(2, 4, 4); #1;
    check("fl_valid", 64'(wb_valid), 0);
    check("fl_res", 64'(wb_result), 0);
    cyc(); wb_ready = 2'b11; #1;
    check("fl_after_valid", 64'(wb_valid), 0);
    check("fl_after_ready", 64'(fu_ready), 64'hf);
    cyc(); wb_ready = 2'b11; #1;
    check("fl_never", 64'(wb_valid), 0);
    // exception pass-through
    do_reset();
    push(2, 6, 'hBEEF);
    fu_exception[2].valid = 1'b1;
    fu_exception[2].cause = 'h5;
    cyc(); wb_ready = 2'b01; #1;
    check("ex_valid_port", 64'(wb_valid), 64'b01);
    check("ex_valid", 64'(wb_exception[0].valid), 1);
    check("ex_cause", 64'(wb_exception[0].cause), 5);
    check("ex_id", 64'(wb_trans_id[0]), 6);
    check("ex_res", 64'(wb_result[0]), 64'hBEEF);
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
